// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: accepts one host request, runs SETUP/ACCESS on the
// slave selected by the upper address bits, and returns data/status as a one-cycle strobe.
module apb_master_ctrl #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 8,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [AWIDTH-1:0]        req_addr,
    input  logic [DWIDTH-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DWIDTH-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [AWIDTH-1:0]        PADDR,
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [DWIDTH-1:0]        PWDATA,
    input  logic [NSLV*DWIDTH-1:0]   PRDATA,
    input  logic [NSLV-1:0]          PREADY
);
    localparam int SW = $clog2(NSLV);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AWIDTH-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [SW-1:0]       idx;
    logic                sel_phase;
    logic                pready_sel;
    logic [DWIDTH-1:0]   prdata_sel;
    logic [DWIDTH-1:0]   prdata_slv [NSLV];

    // The slave index lives in the held address, so no separate index register is needed.
    assign idx       = paddr_q[AWIDTH-1 -: SW];
    assign sel_phase = (state_q == SETUP) || (state_q == ACCESS);

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
            assign prdata_slv[gi] = PRDATA[gi*DWIDTH +: DWIDTH];
            assign PSEL[gi]       = sel_phase && (idx == SW'(gi));
        end
    endgenerate

    assign pready_sel = PREADY[idx];
    assign prdata_sel = prdata_slv[idx];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    // Saturate so a disabled timeout never wraps the counter.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: drives host requests, models the slaves' PREADY/PRDATA,
// and scores responses against a queue of expected {err, rdata} values.
module tb_apb_master_ctrl;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int NS   = 4;
    localparam int TO   = 15;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [AW-1:0]     PADDR;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DW-1:0]     PWDATA;
    logic [NS*DW-1:0]  PRDATA;
    logic [NS-1:0]     PREADY;

    int n_checks = 0;
    int n_fails  = 0;
    int last_polls;
    logic [DW:0] sb [$];

    apb_master_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .NSLV(NS), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Response scoreboard and bus invariants, sampled on the falling edge.
    always @(negedge PCLK) begin
        if (PRESETn) begin
            check_eq("psel_onehot0", {31'd0, $onehot0(PSEL)}, 32'd1);
            if (PENABLE) check_eq("penable_has_psel", {31'd0, |PSEL}, 32'd1);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    $display("rsp: rdata=0x%02h err=%0d (exp rdata=0x%02h err=%0d)",
                             rsp_rdata, rsp_err, e[DW-1:0], e[DW]);
                    check_eq("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[DW-1:0]});
                    check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e[DW]});
                end
            end
        end
    end

    // One host transfer. waits = number of ACCESS cycles with PREADY low before it rises.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int waits, input bit keep);
        int          idx;
        int          polls;
        bit          accepted;
        bit          r;
        bit          err;
        logic [DW:0] e;
        logic [NS-1:0] sel_exp;
        idx     = int'(addr[AW-1 -: 2]);
        sel_exp = NS'(1) << idx;
        err     = (waits > TO);
        e       = {err, (err || wr) ? {DW{1'b0}} : rd};
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        PREADY    = '0;
        for (int s = 0; s < NS; s++) PRDATA[s*DW +: DW] = DW'($urandom);
        PRDATA[idx*DW +: DW] = rd;
        sb.push_back(e);
        polls = 0;
        accepted = 0;
        while (!accepted && polls < 50) begin
            @(negedge PCLK);
            r = req_ready;
            @(posedge PCLK);
            polls++;
            if (r) accepted = 1;
        end
        last_polls = polls;
        if (!accepted) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            return;
        end
        #1;
        if (keep) begin
            req_addr  = addr ^ 8'h3F;
            req_wdata = ~wd;
        end else begin
            req_valid = 1'b0;
        end
        check_eq("setup_psel", {28'd0, PSEL}, {28'd0, sel_exp});
        check_eq("setup_penable", {31'd0, PENABLE}, 32'd0);
        check_eq("setup_paddr", {24'd0, PADDR}, {24'd0, addr});
        check_eq("setup_pwrite", {31'd0, PWRITE}, {31'd0, wr});
        check_eq("setup_pwdata", {24'd0, PWDATA}, {24'd0, wd});
        check_eq("setup_req_ready", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k <= TO; k++) begin
            @(posedge PCLK);
            #1;
            check_eq("access_penable", {31'd0, PENABLE}, 32'd1);
            check_eq("access_psel", {28'd0, PSEL}, {28'd0, sel_exp});
            check_eq("access_paddr", {24'd0, PADDR}, {24'd0, addr});
            check_eq("access_req_ready", {31'd0, req_ready}, 32'd0);
            PREADY = NS'($urandom) & ~sel_exp;
            for (int s = 0; s < NS; s++)
                if (s != idx) PRDATA[s*DW +: DW] = DW'($urandom);
            if (k >= waits) begin
                PREADY[idx] = 1'b1;
                break;
            end
            if (k == TO) break;
        end
        @(posedge PCLK);
        #1;
        check_eq("resp_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("resp_psel", {28'd0, PSEL}, 32'd0);
        check_eq("resp_penable", {31'd0, PENABLE}, 32'd0);
        check_eq("resp_req_ready", {31'd0, req_ready}, 32'd0);
        PREADY = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int polls;
        bit r;
        PRESETn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_psel", {28'd0, PSEL}, 32'd0);
        check_eq("rst_penable", {31'd0, PENABLE}, 32'd0);
        check_eq("rst_paddr", {24'd0, PADDR}, 32'd0);
        check_eq("rst_pwdata", {24'd0, PWDATA}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        xfer(1'b1, 8'h85, 8'h3C, 8'hEE, 0, 1'b0);     // zero-wait write, slave 2
        check_eq("first_accept_polls", last_polls, 32'd1);
        xfer(1'b0, 8'h12, 8'h00, 8'hA5, 3, 1'b0);     // read, 3 wait states, slave 0
        xfer(1'b0, 8'hC0, 8'h77, 8'h99, 1000, 1'b0);  // timeout, slave 3
        xfer(1'b0, 8'hC1, 8'h00, 8'h5C, 0, 1'b0);     // normal after timeout
        xfer(1'b0, 8'hC0, 8'h00, 8'h3E, TO, 1'b0);    // PREADY on counter==TIMEOUT
        xfer(1'b1, 8'h47, 8'h11, 8'h00, 0, 1'b1);     // back-to-back, valid held
        xfer(1'b0, 8'h4A, 8'h22, 8'h5A, 1, 1'b0);
        check_eq("b2b_accept_polls", last_polls, 32'd2);

        // Reset in the middle of ACCESS must drop the transfer silently.
        @(posedge PCLK);
        #1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'hC4;
        PREADY    = '0;
        polls = 0;
        r = 0;
        while (!r && polls < 50) begin
            @(negedge PCLK);
            r = req_ready;
            @(posedge PCLK);
            polls++;
        end
        check_eq("rst_mid_accept", {31'd0, r}, 32'd1);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check_eq("rst_mid_in_access", {31'd0, PENABLE}, 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check_eq("rst_mid_psel", {28'd0, PSEL}, 32'd0);
        check_eq("rst_mid_penable", {31'd0, PENABLE}, 32'd0);
        check_eq("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_mid_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check_eq("rst_mid_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (20) @(posedge PCLK);
        #1;
        check_eq("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        xfer(1'b0, 8'h80, 8'h00, 8'hC3, 2, 1'b0);     // recovery read, slave 2
        repeat (3) @(posedge PCLK);
        #1;
        check_eq("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Single-outstanding APB master that sequences host read/write requests onto a shared APB bus serving up to NSLV register slaves.
- Decodes the target slave from the upper address bits and drives the SETUP and ACCESS phases.
- Waits on the per-slave PREADY, aborts with an error on timeout, and returns read data or status to the host through a valid/ready request channel and a one-cycle response pulse.
- Sits between the system control logic and the APB register slaves.

Parameters:
- DWIDTH, 8, data width of host and APB data paths.
- AWIDTH, 8, address width. The upper SW = clog2(NSLV) bits select the slave.
- NSLV, 4, number of slaves. Must be a power of two, ≥2.
- TIMEOUT, 15, maximum ACCESS wait cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller accepts request (IDLE only).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AWIDTH  request address.
- req_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  DWIDTH  read data (0 for writes or on error).
- rsp_err  out  1  timeout abort flag, qualified by rsp_valid.
- PADDR  out  AWIDTH  APB address.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  NSLV*DWIDTH  slave read buses; slave i uses bits [i*DWIDTH +: DWIDTH].
- PREADY  in  NSLV  per-slave ready.

Behaviour:
- Reset (async, PRESETn low): state IDLE; PSEL = 0, PENABLE = 0, PWRITE = 0, PADDR = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
- Reset asserted mid-transfer drops the transfer; no response is issued after release.
- All other logic is synchronous to PCLK rising edge.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1; PSEL = 0, PENABLE = 0.
  - On req_valid = 1, latch write/addr/wdata, compute idx = req_addr[AWIDTH-1 -: SW], go to SETUP.
  - PADDR/PWRITE/PWDATA load at acceptance and hold until the next acceptance.
- SETUP (exactly 1 cycle): PSEL[idx] = 1, PENABLE = 0. Next state ACCESS; wait counter cleared.
- ACCESS:
  - PSEL[idx] = 1, PENABLE = 1; PADDR/PWRITE/PWDATA stable.
  - If PREADY[idx] = 1: capture PRDATA slice idx into rsp_rdata for reads (0 for writes), rsp_err = 0, go to RESP.
  - Else, if TIMEOUT ≠ 0 and counter == TIMEOUT: rsp_rdata = 0, rsp_err = 1, go to RESP.
  - Else counter increments and state stays in ACCESS.
  - PREADY high on the timeout cycle counts as success.
  - Maximum ACCESS length is TIMEOUT+1 cycles. The counter width is clog2(TIMEOUT+1) and it never wraps.
- RESP (1 cycle):
  - rsp_valid = 1; PSEL = 0, PENABLE = 0; then IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- req_ready = 0 in SETUP, ACCESS and RESP. req_valid in those states is ignored; the host must hold it.
- Minimum turnaround:
  - Request accepted at edge N.
  - SETUP in cycle N+1, ACCESS in N+2.
  - rsp_valid in N+3 with zero-wait PREADY.
  - Next acceptance at N+4. Throughput: one transfer per 4 cycles.
- PREADY of non-selected slaves and PRDATA of non-selected slaves are ignored.
- At most one PSEL bit is high at any time. PENABLE is never high without PSEL.

Test Plan:
- Write, zero wait: req addr=0x85, wdata=0x3C, write=1, PREADY[2]=1 → SETUP cycle with PSEL=4'b0100, PENABLE=0, PADDR=0x85, PWDATA=0x3C; next cycle PENABLE=1; rsp_valid 3 cycles after acceptance with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x12 (slave 0), PREADY[0] high on 4th ACCESS cycle, PRDATA slice0=0xA5 → ACCESS lasts 4 cycles, rsp_rdata=0xA5, rsp_err=0.
- Timeout: TIMEOUT=15, addr=0xC0 (slave 3), PREADY held 0 → 16 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0. The next request proceeds normally.
- Boundary PREADY: PREADY[3] rises exactly on ACCESS cycle 16 (counter==15) → success, rsp_err=0.
- Back-to-back plus ignored request: req_valid held high across two requests → req_ready low in SETUP/ACCESS/RESP, second acceptance in the cycle after RESP. Non-selected PREADY/PRDATA toggling has no effect. PSEL always one-hot or zero.
- Reset mid-ACCESS: assert PRESETn=0 during ACCESS → PSEL, PENABLE, rsp_* go 0 immediately. After release: IDLE, req_ready=1, no rsp_valid pulse.
